// File: rtl/aurora_router_pkg.sv
// Shared constants and types for the Aurora TX routing path.
// Beat geometry: a 1034-bit DFX word is carried as 55 payload bits per
// 64-bit beat, so one frame is ceil(1034/55) = 19 beats.
package aurora_router_pkg;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  localparam int AURORA_DATA_WIDTH = 64;
  localparam int DFX_WORD_WIDTH    = 1034;
  localparam int BEAT_HDR_WIDTH    = 9;
  localparam int BEAT_PAYLOAD_WIDTH = AURORA_DATA_WIDTH - BEAT_HDR_WIDTH;
  localparam int NUMBER_PACKET     = ceil_div(DFX_WORD_WIDTH, BEAT_PAYLOAD_WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Purpose : combinational round-robin picker; first set req bit at or after
//           ptr, searching cyclically upward.
// Latency : zero (pure combinational). Backpressure: none, stateless.
// Ports   : req[N_PORTS] requests, ptr start index -> pick (one-hot),
//           pick_idx (binary index of pick), any (some request present).
module rr_priority_picker
  import aurora_router_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int IDX_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [N_PORTS-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               any
);

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    for (int off = 0; off < N_PORTS; off++) begin
      if (!any && req[(int'(ptr) + off) % N_PORTS]) begin
        any = 1'b1;
        pick[(int'(ptr) + off) % N_PORTS] = 1'b1;
        pick_idx = IDX_W'((int'(ptr) + off) % N_PORTS);
      end
    end
  end

endmodule

// File: rtl/aurora_tx_arbiter.sv
// Purpose : round-robin share of one Aurora TX lane between N_PORTS
//           encapsulators; one frame (NUMBER_PACKET beats) per grant.
// Latency : request->load grant 1 cycle, beats start the cycle after;
//           datapath port_* -> tx_* is combinational (only the select is held).
// Backpr. : port_ready of the owner follows tx_tready combinationally; a
//           source stall longer than TIMEOUT_CYCLES aborts the frame.
// Ports   : port_req/port_gnt load handshake, port_valid/port_data/port_ready
//           beat stream per port, tx_tdata/tvalid/tlast/tready lane side,
//           busy, frame_done and timeout_err status pulses.
module aurora_tx_arbiter
  import aurora_router_pkg::*;
#(
  parameter int N_PORTS           = 4,
  parameter int AURORA_DATA_WIDTH = aurora_router_pkg::AURORA_DATA_WIDTH,
  parameter int NUMBER_PACKET     = aurora_router_pkg::NUMBER_PACKET,
  parameter int TIMEOUT_CYCLES    = 64
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N_PORTS-1:0]                   port_req,
  output logic [N_PORTS-1:0]                   port_gnt,
  input  logic [N_PORTS-1:0]                   port_valid,
  input  logic [N_PORTS*AURORA_DATA_WIDTH-1:0] port_data,
  output logic [N_PORTS-1:0]                   port_ready,
  output logic [AURORA_DATA_WIDTH-1:0]         tx_tdata,
  output logic                                 tx_tvalid,
  output logic                                 tx_tlast,
  input  logic                                 tx_tready,
  output logic                                 busy,
  output logic                                 frame_done,
  output logic                                 timeout_err
);

  localparam int IDX_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int BEAT_W  = (NUMBER_PACKET > 1) ? $clog2(NUMBER_PACKET) : 1;
  localparam int STALL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [BEAT_W-1:0]  LAST_BEAT   = BEAT_W'(NUMBER_PACKET - 1);
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]   LAST_PORT   = IDX_W'(N_PORTS - 1);

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    gidx_q, gidx_d;
  logic [N_PORTS-1:0]  gnt_oh_q, gnt_oh_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic                frame_done_q, frame_done_d;
  logic                timeout_err_q, timeout_err_d;

  logic [N_PORTS-1:0]  pick;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;

  logic [AURORA_DATA_WIDTH-1:0] sel_data;
  logic                         sel_valid;

  rr_priority_picker #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req      (port_req),
    .ptr      (rr_ptr_q),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  assign sel_data  = port_data[int'(gidx_q) * AURORA_DATA_WIDTH +: AURORA_DATA_WIDTH];
  assign sel_valid = port_valid[gidx_q];

  assign busy        = (state_q != IDLE);
  assign frame_done  = frame_done_q;
  assign timeout_err = timeout_err_q;

  always_comb begin
    state_d       = state_q;
    gidx_d        = gidx_q;
    gnt_oh_d      = gnt_oh_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    frame_done_d  = 1'b0;
    timeout_err_d = 1'b0;
    port_gnt      = '0;
    port_ready    = '0;
    tx_tdata      = '0;
    tx_tvalid     = 1'b0;
    tx_tlast      = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gidx_d   = pick_idx;
          gnt_oh_d = pick;
          state_d  = LOAD;
        end
      end

      LOAD: begin
        port_gnt    = gnt_oh_q;
        // Pointer moves past the winner so a port re-requesting right at the
        // end of its frame queues behind everyone else in rotation.
        rr_ptr_d    = (gidx_q == LAST_PORT) ? '0 : gidx_q + 1'b1;
        beat_cnt_d  = '0;
        stall_cnt_d = '0;
        state_d     = STREAM;
      end

      STREAM: begin
        tx_tdata   = sel_data;
        tx_tvalid  = sel_valid;
        tx_tlast   = sel_valid && (beat_cnt_q == LAST_BEAT);
        port_ready = tx_tready ? gnt_oh_q : '0;

        if (sel_valid && tx_tready) begin
          stall_cnt_d = '0;
          if (beat_cnt_q == LAST_BEAT) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end else if (tx_tready) begin
          // The TIMEOUT_CYCLES-th stall cycle is the abort cycle itself, so
          // the counter never has to hold the value TIMEOUT_CYCLES.
          // Cycles with tx_tready low are lane backpressure and leave it alone.
          if (stall_cnt_q == STALL_LIMIT) begin
            state_d       = IDLE;
            timeout_err_d = 1'b1;
          end else begin
            stall_cnt_d = stall_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      gidx_q        <= '0;
      gnt_oh_q      <= '0;
      rr_ptr_q      <= '0;
      beat_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gidx_q        <= gidx_d;
      gnt_oh_q      <= gnt_oh_d;
      rr_ptr_q      <= rr_ptr_d;
      beat_cnt_q    <= beat_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// Purpose : self-checking bench for aurora_tx_arbiter with a transaction-level
//           reference (owner port, beats sent, stall run, rotation pointer).
// Latency : inputs change 1 time unit after the rising edge; outputs are
//           compared on the falling edge.
// Backpr. : tx_tready driven directly or randomly by each scenario.
module tb_aurora_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int NP = 19;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   port_req, port_gnt, port_valid, port_ready;
  logic [N*W-1:0] port_data;
  logic [W-1:0]   tx_tdata;
  logic           tx_tvalid, tx_tlast, tx_tready;
  logic           busy, frame_done, timeout_err;

  always #5 clk = ~clk;

  aurora_tx_arbiter #(
    .N_PORTS           (N),
    .AURORA_DATA_WIDTH (W),
    .NUMBER_PACKET     (NP),
    .TIMEOUT_CYCLES    (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .port_req    (port_req),
    .port_gnt    (port_gnt),
    .port_valid  (port_valid),
    .port_data   (port_data),
    .port_ready  (port_ready),
    .tx_tdata    (tx_tdata),
    .tx_tvalid   (tx_tvalid),
    .tx_tlast    (tx_tlast),
    .tx_tready   (tx_tready),
    .busy        (busy),
    .frame_done  (frame_done),
    .timeout_err (timeout_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Source side: each port presents its head beat until the lane takes it.
  logic [W-1:0] src_data [N];
  logic [N-1:0] consumed;
  logic [N-1:0] drv_req, drv_valid;
  logic         drv_ready;

  // Reference: who owns the lane, whether this is its load cycle, how many
  // beats it has delivered, how long its source has stalled, and where the
  // rotation resumes.
  int m_owner, m_ptr, m_beats, m_stall;
  bit m_load, m_done, m_err;

  // Observations of the DUT, tallied per scenario.
  int obs_beats, obs_last, obs_done, obs_err, obs_vcycles, obs_gnt_cycles;
  int obs_grants[$];
  bit           hold_pending;
  logic [W-1:0] hold_data;

  int exp_order[5] = '{0, 1, 2, 3, 0};

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_beats = 0; m_stall = 0;
    m_load = 0; m_done = 0; m_err = 0;
  endtask

  task automatic clear_obs();
    obs_beats = 0; obs_last = 0; obs_done = 0; obs_err = 0;
    obs_vcycles = 0; obs_gnt_cycles = 0;
    obs_grants.delete();
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < N; i++)
      if (consumed[i]) src_data[i] = {$urandom, $urandom};
    consumed   = '0;
    port_req   = drv_req;
    port_valid = drv_valid;
    tx_tready  = drv_ready;
    for (int i = 0; i < N; i++) port_data[i*W +: W] = src_data[i];
  endtask

  task automatic compare_outputs();
    bit           in_stream;
    logic [N-1:0] e_gnt, e_rdy;
    logic         e_vld, e_last;
    logic [W-1:0] e_dat;
    in_stream = (m_owner >= 0) && !m_load;
    e_gnt = '0; e_rdy = '0; e_vld = 1'b0; e_last = 1'b0; e_dat = '0;
    if (m_owner >= 0 && m_load) e_gnt[m_owner] = 1'b1;
    if (in_stream) begin
      e_vld = port_valid[m_owner];
      e_dat = port_data[m_owner*W +: W];
      if (tx_tready) e_rdy[m_owner] = 1'b1;
      e_last = e_vld && (m_beats == NP - 1);
    end
    check_eq("port_gnt",    port_gnt,    e_gnt);
    check_eq("port_ready",  port_ready,  e_rdy);
    check_eq("tx_tvalid",   tx_tvalid,   e_vld);
    check_eq("tx_tdata",    tx_tdata,    e_dat);
    check_eq("tx_tlast",    tx_tlast,    e_last);
    check_eq("busy",        busy,        m_owner >= 0);
    check_eq("frame_done",  frame_done,  m_done);
    check_eq("timeout_err", timeout_err, m_err);
    if (hold_pending && tx_tvalid) check_eq("tdata_hold", tx_tdata, hold_data);
    hold_pending = tx_tvalid && !tx_tready;
    hold_data    = tx_tdata;

    if (tx_tvalid && tx_tready) obs_beats++;
    if (tx_tvalid && tx_tready && tx_tlast) obs_last++;
    if (tx_tvalid) obs_vcycles++;
    if (frame_done) obs_done++;
    if (timeout_err) obs_err++;
    if (port_gnt != '0) obs_gnt_cycles++;
    for (int i = 0; i < N; i++) if (port_gnt[i]) obs_grants.push_back(i);
  endtask

  task automatic model_advance();
    m_done = 0;
    m_err  = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_owner < 0) begin
      if (port_req != '0) begin
        for (int k = 0; k < N; k++)
          if (m_owner < 0 && port_req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        m_load = 1;
      end
    end else if (m_load) begin
      m_load  = 0;
      m_ptr   = (m_owner + 1) % N;
      m_beats = 0;
      m_stall = 0;
    end else if (tx_tready) begin
      if (port_valid[m_owner]) begin
        consumed[m_owner] = 1'b1;
        m_beats++;
        m_stall = 0;
        if (m_beats == NP) begin
          m_owner = -1;
          m_done  = 1;
        end
      end else begin
        m_stall++;
        if (m_stall == TO) begin
          m_owner = -1;
          m_err   = 1;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_outputs();
    model_advance();
    @(posedge clk);
    #1;
    apply_inputs();
  endtask

  task automatic wait_grant(input int budget);
    int n = 0;
    while (m_owner < 0 && n < budget) begin step(); n++; end
    check_eq("grant_in_time", m_owner >= 0, 1'b1);
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n = 0;
    while ((m_load || m_beats < target) && m_owner >= 0 && n < budget) begin step(); n++; end
    check_eq("beats_in_time", m_beats >= target, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (m_owner >= 0 && n < budget) begin step(); n++; end
    check_eq("idle_in_time", m_owner < 0, 1'b1);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    drv_req = '0; drv_valid = '0; drv_ready = 1'b0;
    consumed = '0; hold_pending = 0; hold_data = '0;
    for (int i = 0; i < N; i++) src_data[i] = {$urandom, $urandom};
    model_reset();
    clear_obs();
    apply_inputs();

    // Reset state, before any clock edge.
    #2;
    check_eq("rst_busy",    busy,       1'b0);
    check_eq("rst_gnt",     port_gnt,   '0);
    check_eq("rst_tvalid",  tx_tvalid,  1'b0);
    check_eq("rst_tdata",   tx_tdata,   '0);
    repeat (3) step();
    rst_n = 1'b1;

    // Fairness: everyone requesting for five frames.
    clear_obs();
    drv_req = '1; drv_valid = '1; drv_ready = 1'b1;
    n = 0;
    while (obs_grants.size() < 5 && n < 400) begin step(); n++; end
    drv_req = '0;
    wait_idle(100);
    check_eq("fair_ngrants", obs_grants.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < obs_grants.size()) check_eq($sformatf("fair_order%0d", k), obs_grants[k], exp_order[k]);
    check_eq("fair_done", obs_done, 5);

    // Single request on port 2.
    clear_obs();
    drv_req = 4'b0100;
    wait_grant(10);
    drv_req = '0;
    wait_idle(100);
    check_eq("single_port",     obs_grants.size() > 0 ? obs_grants[0] : -1, 2);
    check_eq("single_gnt_cyc",  obs_gnt_cycles, 1);
    check_eq("single_beats",    obs_beats, NP);
    check_eq("single_last",     obs_last, 1);
    check_eq("single_done",     obs_done, 1);

    // Lane backpressure: tx_tready alternating, port 3 always valid.
    clear_obs();
    drv_req = 4'b1000;
    wait_grant(10);
    drv_req = '0;
    n = 0;
    while (m_owner >= 0 && n < 200) begin drv_ready = ~drv_ready; step(); n++; end
    drv_ready = 1'b1;
    wait_idle(10);
    check_eq("bp_beats", obs_beats, NP);
    check_eq("bp_err",   obs_err, 0);
    check_eq("bp_last",  obs_last, 1);
    check_eq("bp_span",  (obs_vcycles >= NP*2-1) && (obs_vcycles <= NP*2), 1'b1);

    // Source stall: port 1 sends 5 beats then stops; port 2 waits its turn.
    clear_obs();
    drv_req = 4'b0110; drv_valid = '1; drv_ready = 1'b1;
    wait_grant(10);
    drv_req = 4'b0100;
    wait_beats(4, 50);
    drv_valid = 4'b1101;
    n = 0;
    while (obs_grants.size() < 2 && n < 80) begin step(); n++; end
    check_eq("stall_err",    obs_err, 1);
    check_eq("stall_last",   obs_last, 0);
    check_eq("stall_beats",  obs_beats, 5);
    check_eq("stall_first",  obs_grants.size() > 0 ? obs_grants[0] : -1, 1);
    check_eq("stall_next",   obs_grants.size() > 1 ? obs_grants[1] : -1, 2);
    drv_req = '0; drv_valid = '1;
    wait_idle(100);

    // Source stall hidden under lane backpressure: must not time out.
    clear_obs();
    drv_req = 4'b0010;
    wait_grant(10);
    drv_req = '0;
    wait_beats(4, 50);
    drv_valid = 4'b1101; drv_ready = 1'b0;
    repeat (100) step();
    drv_valid = '1; drv_ready = 1'b1;
    wait_idle(100);
    check_eq("bpstall_err",   obs_err, 0);
    check_eq("bpstall_beats", obs_beats, NP);
    check_eq("bpstall_last",  obs_last, 1);
    check_eq("bpstall_done",  obs_done, 1);

    // Reset in the middle of a frame.
    clear_obs();
    drv_req = 4'b0100;
    wait_grant(10);
    drv_req = '0;
    wait_beats(7, 50);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("mid_rst_tvalid", tx_tvalid,  1'b0);
    check_eq("mid_rst_tdata",  tx_tdata,   '0);
    check_eq("mid_rst_tlast",  tx_tlast,   1'b0);
    check_eq("mid_rst_ready",  port_ready, '0);
    check_eq("mid_rst_busy",   busy,       1'b0);
    clear_obs();
    drv_req = 4'b1001;
    repeat (3) step();
    rst_n = 1'b1;
    n = 0;
    while (obs_grants.size() < 1 && n < 10) begin step(); n++; end
    check_eq("post_rst_first", obs_grants.size() > 0 ? obs_grants[0] : -1, 0);
    drv_req = '0;
    wait_idle(100);

    // Randomized traffic: healthy sources first, then starving ones.
    clear_obs();
    for (int c = 0; c < 2400; c++) begin
      int vp;
      vp = (c < 1600) ? 85 : 20;
      if ($urandom_range(0, 3) == 0) drv_req = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) drv_valid[i] = ($urandom_range(0, 99) < vp);
      drv_ready = ($urandom_range(0, 99) < 75);
      step();
    end
    drv_req = '0; drv_valid = '1; drv_ready = 1'b1;
    wait_idle(200);
    check_eq("rand_frames_seen",   obs_done > 0, 1'b1);
    check_eq("rand_timeouts_seen", obs_err > 0,  1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aurora_tx_arbiter.md
# aurora_tx_arbiter

Round-robin scheduler that shares one Aurora TX lane between `N_PORTS` input-port encapsulators. It grants one port per frame, issues the one-cycle load grant that makes that port's encapsulator capture its DFX word and header, then routes that port's 64-bit beats to the lane with ready/valid backpressure. It counts `NUMBER_PACKET` beats, marks the last one, and recovers from stalled sources with a watchdog. It sits between the per-port encapsulators and the Aurora TX user interface.

## Interface
- `N_PORTS`, 4: number of requesting input ports.
- `AURORA_DATA_WIDTH`, 64: beat width.
- `NUMBER_PACKET`, 19: beats per frame (1034-bit DFX word / 55-bit payload, rounded up).
- `TIMEOUT_CYCLES`, 64: consecutive source-stall cycles before a frame is aborted.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `port_req`  in  N_PORTS  port i has a DFX word pending.
- `port_gnt`  out  N_PORTS  one-hot, one-cycle load grant to the encapsulator.
- `port_valid`  in  N_PORTS  port i beat valid.
- `port_data`  in  N_PORTS*AURORA_DATA_WIDTH  flattened beats; port i occupies bits [i*64 +: 64].
- `port_ready`  out  N_PORTS  beat accepted from port i.
- `tx_tdata`  out  AURORA_DATA_WIDTH  lane data.
- `tx_tvalid`  out  1  lane valid.
- `tx_tlast`  out  1  final beat of frame.
- `tx_tready`  in  1  lane ready.
- `busy`  out  1  high in LOAD and STREAM.
- `frame_done`  out  1  one-cycle pulse after the last beat is accepted.
- `timeout_err`  out  1  one-cycle pulse on abort.

## Operation
- States: IDLE, LOAD, STREAM.
- **IDLE:**
  - If `port_req` is nonzero, pick the first requester at or after `rr_ptr`, cyclically.
  - Register the pick as `gidx` and go to LOAD.
- **LOAD (exactly 1 cycle):**
  - Drive `port_gnt[gidx]=1`.
  - Update `rr_ptr = (gidx+1) mod N_PORTS`.
  - Clear `beat_cnt` and `stall_cnt`, then go to STREAM.
- **STREAM:**
  - `tx_tdata = port_data[gidx]` and `tx_tvalid = port_valid[gidx]`.
  - `port_ready[gidx] = tx_tready`; all other `port_ready` bits are 0.
  - A beat is accepted when `port_valid[gidx]` and `tx_tready` are both high; each accepted beat increments `beat_cnt`.
  - `tx_tlast = tx_tvalid && beat_cnt == NUMBER_PACKET-1`.
  - Normal end: on acceptance of the last beat, go to IDLE and pulse `frame_done` in the next cycle.
- **Watchdog:**
  - `stall_cnt` increments on cycles where `tx_tready=1` and `port_valid[gidx]=0`.
  - It clears on any accepted beat. It holds when `tx_tready=0`, because lane backpressure is not a source stall.
  - When `stall_cnt` reaches `TIMEOUT_CYCLES`, pulse `timeout_err`, go to IDLE and do not assert `tx_tlast`.
- **Boundary cases:**
  - `port_req` changes during STREAM are ignored; `port_req[gidx]` dropping does not end the frame.
  - A port requesting in the same cycle its frame ends is eligible, but only after the other requesters in rotation order.
  - `port_gnt` and `port_ready` never assert outside LOAD and STREAM respectively.
  - `beat_cnt` width is $clog2(NUMBER_PACKET). It never wraps, because the frame ends at NUMBER_PACKET-1.
- **Reset:**
  - Any state goes to IDLE, with `rr_ptr=0`, `gidx=0` and counters 0.
  - All outputs reset to 0 (`tx_tdata=0`, `tx_tvalid=0`, `tx_tlast=0`, `port_gnt=0`, `port_ready=0`, `busy=0`, pulses 0).
  - A partially sent frame is dropped with no `tx_tlast`.

## Timing
- Request to grant: request seen in IDLE at cycle t gives `port_gnt` at t+1 and STREAM from t+2.
- Datapath latency from `port_data`/`port_valid` to `tx_*` is zero (combinational mux); only the select `gidx` is registered.
- `port_ready` is combinational from `tx_tready`; no registered skid stage.
- Minimum frame occupancy is NUMBER_PACKET+1 cycles (LOAD plus 19 beats).
- Back-to-back frames: IDLE costs 1 cycle between frames.
- `frame_done` and `timeout_err` are registered, one cycle after the terminating event, and never in the same cycle.

## Structure
- Shared package `aurora_router_pkg` holds:
  - `AURORA_DATA_WIDTH`, `NUMBER_PACKET`, the header-width constants;
  - the `arb_state_t` enum {IDLE, LOAD, STREAM}.
- One sub-module: `rr_priority_picker`, a combinational round-robin picker.
  - Inputs: `req[N_PORTS]`, `ptr`.
  - Outputs: one-hot `pick`, `pick_idx`, `any`.
- The FSM, counters and mux live in the top module.

## Test plan
- Single request: `port_req=4'b0100` from IDLE, port 2 always valid, `tx_tready=1` → `port_gnt=4'b0100` for exactly 1 cycle; 19 beats on `tx_tdata` equal port 2's data; `tx_tlast` only on beat 19; `frame_done` pulse the next cycle.
- Fairness: all four ports requesting continuously over 5 frames → grant order 0,1,2,3,0; no port is granted twice before the others.
- Lane backpressure: `tx_tready` toggles 1,0,1,0 with port always valid → exactly 19 accepted beats over about 38 cycles; no `timeout_err`; `tx_tdata` stable while `tx_tready=0`.
- Source stall: with `TIMEOUT_CYCLES=16`, port 1 sends 5 beats then drops `port_valid` while `tx_tready=1` → `timeout_err` pulses once; no `tx_tlast`; FSM returns to IDLE; the next requester is granted.
- Stall under backpressure: port 1 drops valid while `tx_tready=0` for 100 cycles → no timeout; the frame completes normally after valid resumes.
- Reset mid-frame: assert `rst_n=0` after beat 7 → all outputs 0 immediately; after release, with ports 0 and 3 requesting, port 0 is granted first.
